// File: rtl/ma_cmd_arbiter.sv
// Two-requester round-robin command arbiter for the memory-access controller.
// One command outstanding at a time; completion is routed back to the owning requester.
module ma_cmd_arbiter #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ma_ddr4_linkup_i,
  input  logic        rq0_valid_i,
  output logic        rq0_ready_o,
  input  logic        rq0_sel_v_m_i,
  input  logic        rq0_store_i,
  input  logic [9:0]  rq0_v_m_reg_i,
  input  logic [4:0]  rq0_a_reg_i,
  input  logic [63:0] rq0_a_offset_i,
  output logic        rq0_done_o,
  input  logic        rq1_valid_i,
  output logic        rq1_ready_o,
  input  logic        rq1_sel_v_m_i,
  input  logic        rq1_store_i,
  input  logic [9:0]  rq1_v_m_reg_i,
  input  logic [4:0]  rq1_a_reg_i,
  input  logic [63:0] rq1_a_offset_i,
  output logic        rq1_done_o,
  output logic        ma_start_o,
  output logic        ma_select_v_m_o,
  output logic        ma_v_load_or_store_o,
  output logic [9:0]  ma_v_m_reg_o,
  output logic [4:0]  ma_a_reg_o,
  output logic [63:0] ma_a_offset_o,
  input  logic        ma_done_i,
  output logic        busy_o,
  output logic        timeout_err_o,
  input  logic        err_clr_i
);

  localparam logic [1:0]  ST_IDLE   = 2'd0;
  localparam logic [1:0]  ST_ISSUE  = 2'd1;
  localparam logic [1:0]  ST_WAIT   = 2'd2;
  localparam logic [1:0]  ST_DRAIN  = 2'd3;
  localparam logic [16:0] TIMEOUT_L = 17'(TIMEOUT_CYCLES);

  logic [1:0]  state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        owner_q, owner_d;
  logic        start_q, start_d;
  logic        done0_q, done0_d;
  logic        done1_q, done1_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        timeout_q, timeout_d;
  logic        sel_q, store_q;
  logic [9:0]  v_m_reg_q;
  logic [4:0]  a_reg_q;
  logic [63:0] a_offset_q;
  logic        gnt0, gnt1, accept, timeout_set;
  logic [16:0] wait_cnt_inc;

  // On a tie, the requester that did not win last time is granted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == ST_IDLE && ma_ddr4_linkup_i && !rst_i) begin
      if (rq0_valid_i && rq1_valid_i) begin
        gnt0 = last_grant_q;
        gnt1 = !last_grant_q;
      end else begin
        gnt0 = rq0_valid_i;
        gnt1 = rq1_valid_i;
      end
    end
  end

  assign accept       = gnt0 | gnt1;
  assign wait_cnt_inc = {1'b0, wait_cnt_q} + 17'd1;
  assign timeout_set  = (state_q == ST_WAIT) && !ma_done_i && (wait_cnt_inc == TIMEOUT_L);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    start_d      = 1'b0;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    wait_cnt_d   = wait_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d      = ST_ISSUE;
          owner_d      = gnt1;
          last_grant_d = gnt1;
          start_d      = 1'b1;
        end
      end
      ST_ISSUE: begin
        // Any ma_done seen here belongs to the previous command.
        state_d    = ST_WAIT;
        wait_cnt_d = '0;
      end
      ST_WAIT: begin
        if (ma_done_i) begin
          state_d = ST_DRAIN;
          done0_d = !owner_q;
          done1_d = owner_q;
        end else if (wait_cnt_q != 16'hFFFF) begin
          wait_cnt_d = wait_cnt_inc[15:0];
        end
      end
      ST_DRAIN: begin
        if (!ma_done_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    timeout_d = timeout_set ? 1'b1 : (err_clr_i ? 1'b0 : timeout_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      start_q      <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      wait_cnt_q   <= '0;
      timeout_q    <= 1'b0;
      sel_q        <= 1'b0;
      store_q      <= 1'b0;
      v_m_reg_q    <= '0;
      a_reg_q      <= '0;
      a_offset_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      start_q      <= start_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      wait_cnt_q   <= wait_cnt_d;
      timeout_q    <= timeout_d;
      if (accept) begin
        sel_q      <= gnt1 ? rq1_sel_v_m_i  : rq0_sel_v_m_i;
        store_q    <= gnt1 ? rq1_store_i    : rq0_store_i;
        v_m_reg_q  <= gnt1 ? rq1_v_m_reg_i  : rq0_v_m_reg_i;
        a_reg_q    <= gnt1 ? rq1_a_reg_i    : rq0_a_reg_i;
        a_offset_q <= gnt1 ? rq1_a_offset_i : rq0_a_offset_i;
      end
    end
  end

  assign rq0_ready_o          = gnt0;
  assign rq1_ready_o          = gnt1;
  assign rq0_done_o           = done0_q;
  assign rq1_done_o           = done1_q;
  assign ma_start_o           = start_q;
  assign ma_select_v_m_o      = sel_q;
  assign ma_v_load_or_store_o = store_q;
  assign ma_v_m_reg_o         = v_m_reg_q;
  assign ma_a_reg_o           = a_reg_q;
  assign ma_a_offset_o        = a_offset_q;
  assign busy_o               = (state_q != ST_IDLE);
  assign timeout_err_o        = timeout_q;

endmodule

// File: tb/tb_ma_cmd_arbiter.sv
// Bench for ma_cmd_arbiter: a command-lifetime model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_ma_cmd_arbiter;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst, linkup, ma_done, err_clr;
  logic [1:0]  rq_valid, rq_sel, rq_store, rq_ready, rq_done;
  logic [9:0]  rq_vm  [2];
  logic [4:0]  rq_ar  [2];
  logic [63:0] rq_off [2];
  logic        ma_start, ma_sel, ma_store, busy, tmo;
  logic [9:0]  ma_vm;
  logic [4:0]  ma_ar;
  logic [63:0] ma_off;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  ma_cmd_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .rst_i(rst), .ma_ddr4_linkup_i(linkup),
    .rq0_valid_i(rq_valid[0]), .rq0_ready_o(rq_ready[0]), .rq0_sel_v_m_i(rq_sel[0]),
    .rq0_store_i(rq_store[0]), .rq0_v_m_reg_i(rq_vm[0]), .rq0_a_reg_i(rq_ar[0]),
    .rq0_a_offset_i(rq_off[0]), .rq0_done_o(rq_done[0]),
    .rq1_valid_i(rq_valid[1]), .rq1_ready_o(rq_ready[1]), .rq1_sel_v_m_i(rq_sel[1]),
    .rq1_store_i(rq_store[1]), .rq1_v_m_reg_i(rq_vm[1]), .rq1_a_reg_i(rq_ar[1]),
    .rq1_a_offset_i(rq_off[1]), .rq1_done_o(rq_done[1]),
    .ma_start_o(ma_start), .ma_select_v_m_o(ma_sel), .ma_v_load_or_store_o(ma_store),
    .ma_v_m_reg_o(ma_vm), .ma_a_reg_o(ma_ar), .ma_a_offset_o(ma_off),
    .ma_done_i(ma_done), .busy_o(busy), .timeout_err_o(tmo), .err_clr_i(err_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a command lives from accept (age 1 = start cycle) until ma_done has
  // been seen after the start cycle and has then dropped.
  logic        m_out, m_cmpl, m_pulse, m_owner, m_last, m_tmo;
  int          m_age, m_waited;
  logic        m_sel, m_store;
  logic [9:0]  m_vm;
  logic [4:0]  m_ar;
  logic [63:0] m_off;
  logic [1:0]  exp_ready;
  logic        m_set;

  assign exp_ready = (!rst && linkup && !m_out) ?
                     ((rq_valid == 2'b11) ? (m_last ? 2'b01 : 2'b10) : rq_valid) : 2'b00;
  assign m_set = m_out && (m_age >= 2) && !m_cmpl && !ma_done && (m_waited + 1 == TMO);

  always @(posedge clk) begin
    if (rst) begin
      m_out <= 1'b0; m_cmpl <= 1'b0; m_pulse <= 1'b0; m_owner <= 1'b0;
      m_last <= 1'b1; m_tmo <= 1'b0; m_age <= 0; m_waited <= 0;
      m_sel <= 1'b0; m_store <= 1'b0; m_vm <= '0; m_ar <= '0; m_off <= '0;
    end else begin
      m_pulse <= 1'b0;
      if (!m_out) begin
        if (exp_ready != 2'b00) begin
          m_out <= 1'b1; m_age <= 1; m_cmpl <= 1'b0; m_waited <= 0;
          m_owner <= exp_ready[1]; m_last <= exp_ready[1];
          m_sel <= rq_sel[exp_ready[1]]; m_store <= rq_store[exp_ready[1]];
          m_vm <= rq_vm[exp_ready[1]]; m_ar <= rq_ar[exp_ready[1]];
          m_off <= rq_off[exp_ready[1]];
        end
      end else begin
        m_age <= m_age + 1;
        if (m_age >= 2 && !m_cmpl) begin
          if (ma_done) begin
            m_cmpl <= 1'b1; m_pulse <= 1'b1;
          end else begin
            m_waited <= m_waited + 1;
          end
        end else if (m_cmpl && !ma_done) begin
          m_out <= 1'b0;
        end
      end
      if (m_set) m_tmo <= 1'b1;
      else if (err_clr) m_tmo <= 1'b0;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("busy", 64'(busy), 64'(m_out));
        chk("ma_start", 64'(ma_start), 64'(m_out && m_age == 1));
        chk("ready", 64'(rq_ready), 64'(exp_ready));
        chk("done", 64'(rq_done), m_pulse ? (m_owner ? 64'd2 : 64'd1) : 64'd0);
        chk("timeout_err", 64'(tmo), 64'(m_tmo));
        chk("ma_select_v_m", 64'(ma_sel), 64'(m_sel));
        chk("ma_store", 64'(ma_store), 64'(m_store));
        chk("ma_v_m_reg", 64'(ma_vm), 64'(m_vm));
        chk("ma_a_reg", 64'(ma_ar), 64'(m_ar));
        chk("ma_a_offset", ma_off, m_off);
      end
    end
  end

  int  done_cnt0 = 0, done_cnt1 = 0, fall_cyc = -1;
  bit  done_prev = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (rq_done[0]) done_cnt0++;
      if (rq_done[1]) done_cnt1++;
      if (done_prev && !ma_done) fall_cyc = cyc;
      done_prev = ma_done;
    end
  end

  // Memory-access controller stand-in: ma_done rises resp_delay cycles after ma_start.
  int resp_delay = 5, resp_hold = 1;
  bit resp_kill = 1'b0;
  initial begin
    ma_done = 1'b0;
    forever begin
      @(negedge clk);
      if (ma_start) begin
        for (int i = 0; i < resp_delay; i++) @(posedge clk);
        #1;
        if (!resp_kill) begin
          ma_done = 1'b1;
          for (int i = 0; i < resp_hold; i++) @(posedge clk);
          #1 ma_done = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(output logic who);
    bit found = 1'b0;
    who = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ((rq_ready & rq_valid) != 2'b00) begin
        who = rq_ready[1];
        found = 1'b1;
        break;
      end
    end
    chk("accept_seen", 64'(found), 64'd1);
  endtask

  task automatic wait_start(output int s);
    bit found = 1'b0;
    s = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ma_start) begin
        s = cyc;
        found = 1'b1;
        break;
      end
    end
    chk("start_seen", 64'(found), 64'd1);
  endtask

  task automatic wait_idle();
    bit found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) begin
        found = 1'b1;
        break;
      end
    end
    chk("idle_reached", 64'(found), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  logic order [4];
  logic g;
  int   s, s2, d0, d1;

  initial begin
    rst = 1'b1; linkup = 1'b0; err_clr = 1'b0;
    rq_valid = 2'b00; rq_sel = 2'b00; rq_store = 2'b00;
    for (int i = 0; i < 2; i++) begin
      rq_vm[i] = '0; rq_ar[i] = '0; rq_off[i] = '0;
    end
    tick();
    chk_en = 1'b1;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_timeout", 64'(tmo), 64'd0);
    chk("rst_offset", ma_off, 64'd0);
    tick();

    // Link down blocks accepts; link up grants and starts one cycle later.
    rq_sel[0] = 1'b1; rq_vm[0] = 10'h011; rq_ar[0] = 5'd3; rq_off[0] = 64'h40;
    rq_valid = 2'b01;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("linkdown_ready0", 64'(rq_ready[0]), 64'd0);
      tick();
    end
    linkup = 1'b1;
    @(negedge clk);
    chk("linkup_ready0", 64'(rq_ready[0]), 64'd1);
    tick();
    rq_valid = 2'b00;
    @(negedge clk);
    chk("start_after_accept", 64'(ma_start), 64'd1);
    wait_idle();
    tick();

    // Fresh reset, then both requesters contend for four commands.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    d0 = done_cnt0; d1 = done_cnt1;
    rq_sel = 2'b00; rq_store = 2'b10;
    rq_vm[0] = 10'h100; rq_vm[1] = 10'h200; rq_off[0] = 64'h0; rq_off[1] = 64'h8000;
    rq_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_accept(g);
      order[k] = g;
      tick();
      rq_vm[g] = rq_vm[g] + 10'd1;
      rq_off[g] = rq_off[g] + 64'h100;
      if (k == 3) rq_valid = 2'b00;
    end
    wait_idle();
    tick();
    chk("grant0", 64'(order[0]), 64'd0);
    chk("grant1", 64'(order[1]), 64'd1);
    chk("grant2", 64'(order[2]), 64'd0);
    chk("grant3", 64'(order[3]), 64'd1);
    chk("rr_done0_count", 64'(done_cnt0 - d0), 64'd2);
    chk("rr_done1_count", 64'(done_cnt1 - d1), 64'd2);

    // Field latching and stability for an rq1 vector store.
    rq_sel[1] = 1'b0; rq_store[1] = 1'b1; rq_vm[1] = 10'h2A5; rq_ar[1] = 5'd7;
    rq_off[1] = 64'h1000;
    rq_valid = 2'b10;
    wait_accept(g);
    chk("fields_owner", 64'(g), 64'd1);
    tick();
    rq_valid = 2'b00;
    rq_sel[1] = 1'b1; rq_store[1] = 1'b0; rq_vm[1] = 10'h3FF; rq_ar[1] = 5'd31;
    rq_off[1] = 64'hDEAD;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy) break;
      chk("hold_sel", 64'(ma_sel), 64'd0);
      chk("hold_store", 64'(ma_store), 64'd1);
      chk("hold_v_m_reg", 64'(ma_vm), 64'h2A5);
      chk("hold_a_reg", 64'(ma_ar), 64'd7);
      chk("hold_a_offset", ma_off, 64'h1000);
    end
    chk("post_drain_v_m_reg", 64'(ma_vm), 64'h2A5);
    tick();

    // ma_done held three cycles: one pulse, restart only after it falls.
    resp_hold = 3;
    d0 = done_cnt0;
    rq_vm[0] = 10'h055; rq_off[0] = 64'h2000;
    rq_valid = 2'b01;
    wait_accept(g);
    tick();
    wait_start(s);
    wait_start(s2);
    chk("restart_after_fall", 64'(s2 > fall_cyc && fall_cyc > s), 64'd1);
    chk("held_done_pulses", 64'(done_cnt0 - d0), 64'd1);
    tick();
    rq_valid = 2'b00;
    wait_idle();
    tick();
    resp_hold = 1;

    // Timeout: ma_done arrives 15 cycles after start.
    resp_delay = 15;
    rq_valid = 2'b01;
    wait_accept(g);
    tick();
    rq_valid = 2'b00;
    wait_start(s);
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      chk("tmo_before_limit", 64'(tmo), 64'd0);
    end
    @(negedge clk);
    chk("tmo_at_limit", 64'(tmo), 64'd1);
    chk("tmo_still_busy", 64'(busy), 64'd1);
    tick();
    d0 = done_cnt0;
    wait_idle();
    tick();
    chk("late_done_pulse", 64'(done_cnt0 - d0), 64'd1);
    chk("tmo_sticky", 64'(tmo), 64'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    chk("tmo_cleared", 64'(tmo), 64'd0);
    tick();

    // Set wins over a simultaneous clear.
    resp_delay = 12;
    err_clr = 1'b1;
    rq_valid = 2'b01;
    wait_accept(g);
    tick();
    rq_valid = 2'b00;
    wait_start(s);
    for (int i = 0; i < TMO; i++) @(negedge clk);
    @(negedge clk);
    chk("set_wins", 64'(tmo), 64'd1);
    @(negedge clk);
    chk("clear_after_set", 64'(tmo), 64'd0);
    tick();
    err_clr = 1'b0;
    wait_idle();
    tick();

    // Reset during WAIT_DONE drops the command and restores rq0 priority.
    resp_delay = 30;
    resp_kill = 1'b1;
    rq_valid = 2'b01;
    wait_accept(g);
    tick();
    rq_valid = 2'b00;
    wait_start(s);
    @(negedge clk);
    @(negedge clk);
    tick();
    d0 = done_cnt0; d1 = done_cnt1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_offset", ma_off, 64'd0);
    for (int i = 0; i < 35; i++) tick();
    chk("rst_mid_no_done", 64'((done_cnt0 - d0) + (done_cnt1 - d1)), 64'd0);
    resp_kill = 1'b0;
    resp_delay = 5;
    rq_valid = 2'b11;
    @(negedge clk);
    chk("tie_after_reset", 64'(rq_ready), 64'd1);
    tick();
    rq_valid = 2'b00;
    wait_idle();
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
